// File: rtl/axilite_timer.sv
// axilite_timer: AXI4-Lite slave with a 32-bit reloadable down-counter and a level interrupt.
// The optional prescaler is compiled in when AXILITE_TIMER_PRESCALER_EN is defined.
// Register offsets use addr[4:2]: CTRL, STATUS, LOAD, COUNT, PRESCALE, then three unmapped slots.
module axilite_timer #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                    clock_i,
    input  logic                    reset_ni,
    output logic                    int_o,
    input  logic [ADDR_WIDTH-1:0]   s_axilite_awaddr,
    input  logic [2:0]              s_axilite_awprot,
    input  logic                    s_axilite_awvalid,
    output logic                    s_axilite_awready,
    input  logic [DATA_WIDTH-1:0]   s_axilite_wdata,
    input  logic [DATA_WIDTH/8-1:0] s_axilite_wstrb,
    input  logic                    s_axilite_wvalid,
    output logic                    s_axilite_wready,
    output logic [1:0]              s_axilite_bresp,
    output logic                    s_axilite_bvalid,
    input  logic                    s_axilite_bready,
    input  logic [ADDR_WIDTH-1:0]   s_axilite_araddr,
    input  logic [2:0]              s_axilite_arprot,
    input  logic                    s_axilite_arvalid,
    output logic                    s_axilite_arready,
    output logic [DATA_WIDTH-1:0]   s_axilite_rdata,
    output logic [1:0]              s_axilite_rresp,
    output logic                    s_axilite_rvalid,
    input  logic                    s_axilite_rready
);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // The datapath is built for a 32-bit bus only.
    if (DATA_WIDTH != 32) begin : g_bad_data_width
        $error("axilite_timer: DATA_WIDTH must be 32");
    end
    if (ADDR_WIDTH < 6) begin : g_bad_addr_width
        $error("axilite_timer: ADDR_WIDTH must be at least 6");
    end

    logic        aw_held_q, w_held_q;
    logic [2:0]  aw_idx_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic        awready_q, wready_q, bvalid_q, arready_q, rvalid_q;
    logic [1:0]  bresp_q, rresp_q;
    logic [31:0] rdata_q;
    logic        en_q, auto_q, ie_q, pend_q, int_q;
    logic [31:0] load_q, count_q;

    logic        aw_hs, w_hs, ar_hs, commit;
    logic        aw_held_n, w_held_n, bvalid_n, rvalid_n;
    logic [31:0] wmask;
    logic        wr_ctrl, wr_status, wr_load, wr_count;
    logic        tick;
    logic        en_n, auto_n, ie_n, pend_n;
    logic [31:0] load_n, count_n;
    logic [31:0] rd_data;
    logic        rd_err;
    logic        unused_inputs;

    assign s_axilite_awready = awready_q;
    assign s_axilite_wready  = wready_q;
    assign s_axilite_bvalid  = bvalid_q;
    assign s_axilite_bresp   = bresp_q;
    assign s_axilite_arready = arready_q;
    assign s_axilite_rvalid  = rvalid_q;
    assign s_axilite_rresp   = rresp_q;
    assign s_axilite_rdata   = rdata_q;
    assign int_o             = int_q;

    // Only addr[4:2] is decoded; prot is ignored.
    assign unused_inputs = ^{s_axilite_awaddr[ADDR_WIDTH-1:5], s_axilite_awaddr[1:0],
                             s_axilite_araddr[ADDR_WIDTH-1:5], s_axilite_araddr[1:0],
                             s_axilite_awprot, s_axilite_arprot};

    // Handshakes and next state of the single-outstanding write/read tracking.
    assign aw_hs     = s_axilite_awvalid & awready_q;
    assign w_hs      = s_axilite_wvalid & wready_q;
    assign ar_hs     = s_axilite_arvalid & arready_q;
    assign commit    = aw_held_q & w_held_q;
    assign aw_held_n = ~commit & (aw_held_q | aw_hs);
    assign w_held_n  = ~commit & (w_held_q | w_hs);
    assign bvalid_n  = commit | (bvalid_q & ~s_axilite_bready);
    assign rvalid_n  = ar_hs | (rvalid_q & ~s_axilite_rready);

    assign wmask     = {{8{wstrb_q[3]}}, {8{wstrb_q[2]}}, {8{wstrb_q[1]}}, {8{wstrb_q[0]}}};
    assign wr_ctrl   = commit & (aw_idx_q == 3'd0);
    assign wr_status = commit & (aw_idx_q == 3'd1);
    assign wr_load   = commit & (aw_idx_q == 3'd2);
    assign wr_count  = commit & (aw_idx_q == 3'd3);

`ifdef AXILITE_TIMER_PRESCALER_EN
    logic [15:0] prescale_q, presc_cnt_q;
    logic        wr_presc;

    assign wr_presc = commit & (aw_idx_q == 3'd4);
    assign tick     = (presc_cnt_q == prescale_q);

    // Prescale register and divider; the divider restarts while disabled or on reprogramming.
    always_ff @(posedge clock_i) begin
        if (!reset_ni) begin
            prescale_q  <= '0;
            presc_cnt_q <= '0;
        end else begin
            if (wr_presc) begin
                prescale_q <= (prescale_q & ~wmask[15:0]) | (wdata_q[15:0] & wmask[15:0]);
            end
            if (!en_q || wr_presc || tick) begin
                presc_cnt_q <= '0;
            end else begin
                presc_cnt_q <= presc_cnt_q + 16'd1;
            end
        end
    end
`else
    assign tick = 1'b1;
`endif

    // Counter update, then software writes on the commit edge take precedence.
    always_comb begin
        en_n    = en_q;
        auto_n  = auto_q;
        ie_n    = ie_q;
        count_n = count_q;
        load_n  = load_q;
        pend_n  = pend_q;
        if (tick && en_q) begin
            if (count_q != 32'd0) begin
                count_n = count_q - 32'd1;
            end else begin
                pend_n = 1'b1;
                if (auto_q) begin
                    count_n = load_q;
                end else begin
                    en_n = 1'b0;
                end
            end
        end
        if (wr_status && wstrb_q[0] && wdata_q[0] && !(tick && en_q && count_q == 32'd0)) begin
            pend_n = 1'b0;
        end
        if (wr_ctrl && wstrb_q[0]) begin
            {ie_n, auto_n, en_n} = wdata_q[2:0];
        end
        if (wr_count) begin
            count_n = (count_q & ~wmask) | (wdata_q & wmask);
        end
        if (wr_load) begin
            load_n = (load_q & ~wmask) | (wdata_q & wmask);
        end
    end

    // Read data mux, sampled at the AR handshake.
    always_comb begin
        rd_data = '0;
        rd_err  = 1'b0;
        case (s_axilite_araddr[4:2])
            3'd0: rd_data = {29'd0, ie_q, auto_q, en_q};
            3'd1: rd_data = {31'd0, pend_q};
            3'd2: rd_data = load_q;
            3'd3: rd_data = count_q;
`ifdef AXILITE_TIMER_PRESCALER_EN
            3'd4: rd_data = {16'd0, prescale_q};
`else
            3'd4: rd_data = '0;
`endif
            default: rd_err = 1'b1;
        endcase
    end

    // Bus channel registers and timer state.
    always_ff @(posedge clock_i) begin
        if (!reset_ni) begin
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            aw_idx_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rresp_q   <= RESP_OKAY;
            rdata_q   <= '0;
            en_q      <= 1'b0;
            auto_q    <= 1'b0;
            ie_q      <= 1'b0;
            pend_q    <= 1'b0;
            int_q     <= 1'b0;
            load_q    <= '0;
            count_q   <= '0;
        end else begin
            aw_held_q <= aw_held_n;
            w_held_q  <= w_held_n;
            if (aw_hs) begin
                aw_idx_q <= s_axilite_awaddr[4:2];
            end
            if (w_hs) begin
                wdata_q <= s_axilite_wdata;
                wstrb_q <= s_axilite_wstrb;
            end
            awready_q <= ~aw_held_n & ~bvalid_n;
            wready_q  <= ~w_held_n & ~bvalid_n;
            bvalid_q  <= bvalid_n;
            if (commit) begin
                bresp_q <= (aw_idx_q >= 3'd5) ? RESP_SLVERR : RESP_OKAY;
            end
            arready_q <= ~rvalid_n;
            rvalid_q  <= rvalid_n;
            if (ar_hs) begin
                rdata_q <= rd_data;
                rresp_q <= rd_err ? RESP_SLVERR : RESP_OKAY;
            end
            en_q    <= en_n;
            auto_q  <= auto_n;
            ie_q    <= ie_n;
            pend_q  <= pend_n;
            load_q  <= load_n;
            count_q <= count_n;
            int_q   <= pend_q & ie_q;
        end
    end

endmodule

// File: tb/tb_axilite_timer.sv
// tb_axilite_timer: directed self-checking bench for axilite_timer.
// Inputs are driven and outputs sampled 1 time unit after each rising clock edge.
module tb_axilite_timer;

    logic        clk;
    logic        rst_n;
    logic        int_o;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [2:0]  awprot, arprot;
    logic [3:0]  wstrb;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [1:0]  bresp, rresp;

    int n_vec;
    int n_miss;

    axilite_timer #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clock_i          (clk),
        .reset_ni         (rst_n),
        .int_o            (int_o),
        .s_axilite_awaddr (awaddr),
        .s_axilite_awprot (awprot),
        .s_axilite_awvalid(awvalid),
        .s_axilite_awready(awready),
        .s_axilite_wdata  (wdata),
        .s_axilite_wstrb  (wstrb),
        .s_axilite_wvalid (wvalid),
        .s_axilite_wready (wready),
        .s_axilite_bresp  (bresp),
        .s_axilite_bvalid (bvalid),
        .s_axilite_bready (bready),
        .s_axilite_araddr (araddr),
        .s_axilite_arprot (arprot),
        .s_axilite_arvalid(arvalid),
        .s_axilite_arready(arready),
        .s_axilite_rdata  (rdata),
        .s_axilite_rresp  (rresp),
        .s_axilite_rvalid (rvalid),
        .s_axilite_rready (rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Write with AW and W presented together; returns one cycle after the B handshake edge.
    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output logic [1:0] resp);
        int  n;
        logic aw_ok, w_ok;
        awaddr = addr; wdata = data; wstrb = strb;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        n = 0;
        while ((awvalid || wvalid) && n < 50) begin
            aw_ok = awvalid && awready;
            w_ok  = wvalid && wready;
            step();
            if (aw_ok) awvalid = 1'b0;
            if (w_ok)  wvalid = 1'b0;
            n++;
        end
        n = 0;
        while (!bvalid && n < 50) begin
            step();
            n++;
        end
        resp = bresp;
        if (!bvalid) begin
            n_vec++; n_miss++;
            $display("FAIL write_timeout addr=%h: no bvalid within 50 cycles", addr);
        end
        step();
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0;
    endtask

    // Single read; returns one cycle after the R handshake edge.
    task automatic axi_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
        int n;
        araddr = addr; arvalid = 1'b1; rready = 1'b0;
        n = 0;
        while (!arready && n < 50) begin
            step();
            n++;
        end
        step();
        arvalid = 1'b0;
        n = 0;
        while (!rvalid && n < 50) begin
            step();
            n++;
        end
        data = rdata;
        resp = rresp;
        if (!rvalid) begin
            n_vec++; n_miss++;
            $display("FAIL read_timeout addr=%h: no rvalid within 50 cycles", addr);
        end
        rready = 1'b1;
        step();
        rready = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        logic [1:0]  r;
        logic [31:0] exp_reg [5];
        rst_n = 1'b0;
        repeat (3) step();
        n_vec++;
        if ({awready, wready, arready, bvalid, rvalid, int_o} !== 6'b0) begin
            n_miss++;
            $display("FAIL reset_flags: got %b expected 000000", {awready, wready, arready, bvalid, rvalid, int_o});
        end
        n_vec++;
        if ({bresp, rresp, rdata} !== 36'h0) begin
            n_miss++;
            $display("FAIL reset_data: got bresp=%b rresp=%b rdata=%h expected 0", bresp, rresp, rdata);
        end
        rst_n = 1'b1;
        step();
        exp_reg = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
        for (int i = 0; i < 5; i++) begin
            axi_read(32'(i * 4), d, r);
            n_vec++;
            if (d !== exp_reg[i] || r !== 2'b00) begin
                n_miss++;
                $display("FAIL reset_read off=%0h: got %h/%b expected %h/00", i * 4, d, r, exp_reg[i]);
            end
        end
    endtask

    task automatic test_periodic();
        logic [1:0]  r;
        logic [31:0] cexp;
        logic        pexp, iexp;
        axi_write(32'h08, 32'd3, 4'hF, r);
        axi_write(32'h0C, 32'd3, 4'hF, r);
        axi_write(32'h00, 32'h7, 4'hF, r);
        // k=0 is one edge after the CTRL commit edge, where COUNT has already stepped to 2.
        for (int k = 0; k < 44; k++) begin
            cexp = 32'(3 - ((k + 1) % 4));
            pexp = (k >= 3);
            iexp = (k >= 4);
            n_vec++;
            if (dut.count_q !== cexp || dut.pend_q !== pexp || int_o !== iexp) begin
                n_miss++;
                $display("FAIL periodic k=%0d: got count=%0d pend=%b int=%b expected %0d/%b/%b",
                         k, dut.count_q, dut.pend_q, int_o, cexp, pexp, iexp);
            end
            step();
        end
        axi_write(32'h00, 32'h0, 4'hF, r);
        axi_write(32'h04, 32'h1, 4'hF, r);
    endtask

    task automatic test_oneshot();
        logic [1:0]  r;
        logic [31:0] d;
        logic [31:0] cexp;
        axi_write(32'h0C, 32'd5, 4'hF, r);
        axi_write(32'h00, 32'h5, 4'hF, r);
        for (int k = 0; k < 8; k++) begin
            cexp = (k <= 4) ? 32'(4 - k) : 32'd0;
            n_vec++;
            if (dut.count_q !== cexp || dut.pend_q !== (k >= 5) || int_o !== (k >= 6)) begin
                n_miss++;
                $display("FAIL oneshot k=%0d: got count=%0d pend=%b int=%b expected %0d/%b/%b",
                         k, dut.count_q, dut.pend_q, int_o, cexp, (k >= 5), (k >= 6));
            end
            step();
        end
        axi_read(32'h00, d, r);
        n_vec++;
        if (d !== 32'h4) begin
            n_miss++;
            $display("FAIL oneshot_ctrl: got %h expected 00000004", d);
        end
        axi_read(32'h0C, d, r);
        n_vec++;
        if (d !== 32'h0) begin
            n_miss++;
            $display("FAIL oneshot_count: got %h expected 00000000", d);
        end
        axi_write(32'h04, 32'h1, 4'hF, r);
        n_vec++;
        if (int_o !== 1'b0 || dut.pend_q !== 1'b0) begin
            n_miss++;
            $display("FAIL w1c_clear: got int=%b pend=%b expected 0/0", int_o, dut.pend_q);
        end
    endtask

    task automatic test_write_orders();
        int          aw_at, w_at, cyc, bcyc;
        logic        aw_done, w_done, b_done, aw_ok, w_ok, b_ok;
        logic [31:0] val, d;
        logic [1:0]  r, br;
        for (int mode = 0; mode < 3; mode++) begin
            aw_at = (mode == 1) ? 3 : 0;
            w_at  = (mode == 0) ? 3 : 0;
            val   = 32'h1234_5600 + 32'(mode);
            awaddr = 32'h08; wdata = val; wstrb = 4'hF;
            aw_done = 1'b0; w_done = 1'b0; b_done = 1'b0;
            cyc = 0; bcyc = 0; br = 2'b11;
            while (!b_done && cyc < 40) begin
                awvalid = !aw_done && (cyc >= aw_at);
                wvalid  = !w_done && (cyc >= w_at);
                bready  = bvalid && (bcyc >= 4);
                aw_ok = awvalid && awready;
                w_ok  = wvalid && wready;
                b_ok  = bvalid && bready;
                if (aw_done || w_done) begin
                    n_vec++;
                    if ((aw_done && awready !== 1'b0) || (w_done && wready !== 1'b0)) begin
                        n_miss++;
                        $display("FAIL order%0d_ready cyc=%0d: got awready=%b wready=%b expected 0 while held",
                                 mode, cyc, awready, wready);
                    end
                end
                if (bvalid) begin
                    br = bresp;
                    bcyc++;
                end
                step();
                if (aw_ok) aw_done = 1'b1;
                if (w_ok)  w_done = 1'b1;
                if (b_ok)  b_done = 1'b1;
                cyc++;
            end
            awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0;
            n_vec++;
            if (!b_done || bcyc != 5 || br !== 2'b00 || bvalid !== 1'b0) begin
                n_miss++;
                $display("FAIL order%0d_b: got done=%b held=%0d bresp=%b bvalid=%b expected 1/5/00/0",
                         mode, b_done, bcyc, br, bvalid);
            end
            axi_read(32'h08, d, r);
            n_vec++;
            if (d !== val) begin
                n_miss++;
                $display("FAIL order%0d_load: got %h expected %h", mode, d, val);
            end
        end
        axi_write(32'h08, 32'h0, 4'hF, r);
        axi_write(32'h08, 32'hAABBCCDD, 4'b0010, r);
        axi_read(32'h08, d, r);
        n_vec++;
        if (d !== 32'h0000CC00) begin
            n_miss++;
            $display("FAIL wstrb_load: got %h expected 0000cc00", d);
        end
    endtask

    task automatic test_errors_and_race();
        logic [31:0] d;
        logic [1:0]  r;
        axi_write(32'h18, 32'hFFFF_FFFF, 4'hF, r);
        n_vec++;
        if (r !== 2'b10) begin
            n_miss++;
            $display("FAIL unmapped_bresp: got %b expected 10", r);
        end
        axi_read(32'h1C, d, r);
        n_vec++;
        if (d !== 32'h0 || r !== 2'b10) begin
            n_miss++;
            $display("FAIL unmapped_read: got %h/%b expected 00000000/10", d, r);
        end
        // One-shot with COUNT=2: expiry lands two edges after the following STATUS write begins,
        // which is exactly that write's commit edge.
        axi_write(32'h0C, 32'd2, 4'hF, r);
        axi_write(32'h00, 32'h1, 4'hF, r);
        axi_write(32'h04, 32'h1, 4'hF, r);
        axi_read(32'h04, d, r);
        n_vec++;
        if (d !== 32'h1) begin
            n_miss++;
            $display("FAIL w1c_race: got status %h expected 00000001", d);
        end
        axi_write(32'h04, 32'h1, 4'hF, r);
        axi_read(32'h04, d, r);
        n_vec++;
        if (d !== 32'h0) begin
            n_miss++;
            $display("FAIL w1c_after_race: got status %h expected 00000000", d);
        end
    endtask

    task automatic test_prescale();
        logic [31:0] d, cexp;
        logic [1:0]  r;
`ifdef AXILITE_TIMER_PRESCALER_EN
        int ticks;
        axi_write(32'h10, 32'h2, 4'hF, r);
        axi_write(32'h08, 32'd1, 4'hF, r);
        axi_write(32'h0C, 32'd1, 4'hF, r);
        axi_write(32'h00, 32'h3, 4'hF, r);
        // Ticks fall on the 3rd, 6th, ... edge after the CTRL commit; k=0 is commit+1.
        for (int k = 0; k < 18; k++) begin
            ticks = (k + 1) / 3;
            cexp = (ticks % 2 == 0) ? 32'd1 : 32'd0;
            n_vec++;
            if (dut.count_q !== cexp || dut.pend_q !== (ticks >= 2)) begin
                n_miss++;
                $display("FAIL prescale k=%0d: got count=%0d pend=%b expected %0d/%b",
                         k, dut.count_q, dut.pend_q, cexp, (ticks >= 2));
            end
            step();
        end
        axi_write(32'h00, 32'h0, 4'hF, r);
        axi_read(32'h10, d, r);
        n_vec++;
        if (d !== 32'h2) begin
            n_miss++;
            $display("FAIL prescale_read: got %h expected 00000002", d);
        end
`else
        cexp = 32'h0;
        axi_write(32'h10, 32'h5, 4'hF, r);
        n_vec++;
        if (r !== 2'b00) begin
            n_miss++;
            $display("FAIL prescale_bresp: got %b expected 00", r);
        end
        axi_read(32'h10, d, r);
        n_vec++;
        if (d !== cexp || r !== 2'b00) begin
            n_miss++;
            $display("FAIL prescale_read: got %h/%b expected 00000000/00", d, r);
        end
`endif
    endtask

    initial begin
        n_vec = 0; n_miss = 0;
        rst_n = 1'b0;
        awaddr = '0; awprot = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
        araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;
        test_reset();
        test_periodic();
        test_oneshot();
        test_write_orders();
        test_errors_and_race();
        test_prescale();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
